// File: rtl/display_scan_if.sv
// Control inputs and display drive outputs of the multiplexed display scanner.
interface display_scan_if #(
  parameter int DIGITS = 4
);
  logic                  tick;
  logic                  enable;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [DIGITS-1:0]     an;
  logic [3:0]            hex;
  logic                  dp;
  logic [2:0]            digit_idx;
  logic                  frame_done;

  modport master (
    output tick, enable, digits, dp_in, blank_in,
    input  an, hex, dp, digit_idx, frame_done
  );

  modport slave (
    input  tick, enable, digits, dp_in, blank_in,
    output an, hex, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: one digit slot per tick with
// optional all-off guard ticks between slots; every output is registered.
module display_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int GUARD  = 1
) (
  input logic           fastclock,
  input logic           reset,
  display_scan_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GUARD} state_e;

  localparam logic [2:0] LAST_IDX   = 3'(DIGITS - 1);
  localparam logic [1:0] GUARD_LOAD = 2'(GUARD);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d, idx_next;
  logic [1:0]        guard_q, guard_d;
  logic [3:0]        hex_q, hex_d;
  logic              dp_q, dp_d;
  logic              blank_q, blank_d;
  logic              frame_done_q, frame_done_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              load;

  assign idx_next = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;

  always_ff @(posedge fastclock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      guard_q      <= '0;
      hex_q        <= '0;
      dp_q         <= 1'b0;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
    end else begin
      // NOTE: non-blocking so every register samples its peers' pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      guard_q      <= guard_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    guard_d      = guard_q;
    frame_done_d = 1'b0;
    load         = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      guard_d = '0;
    end else if (bus.tick) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          idx_d   = '0;
          load    = 1'b1;
        end
        ST_SHOW: begin
          if (GUARD == 0) begin
            idx_d        = idx_next;
            load         = 1'b1;
            frame_done_d = (idx_q == LAST_IDX);
          end else begin
            state_d = ST_GUARD;
            guard_d = GUARD_LOAD;
          end
        end
        ST_GUARD: begin
          guard_d = guard_q - 2'd1;
          if (guard_q == 2'd1) begin
            state_d      = ST_SHOW;
            idx_d        = idx_next;
            load         = 1'b1;
            frame_done_d = (idx_q == LAST_IDX);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Slot contents are captured only on slot entry and held until the next one.
    hex_d   = hex_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_d == 3'(i)) begin
          hex_d   = bus.digits[4*i +: 4];
          dp_d    = bus.dp_in[i];
          blank_d = bus.blank_in[i];
        end
      end
    end
  end

  // Anodes are derived from next-state values so a single register edge moves them.
  always_comb begin
    an_d = '1;
    if (state_d == ST_SHOW && !blank_d) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_d == 3'(i)) an_d[i] = 1'b0;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.hex        = hex_q;
  assign bus.dp         = dp_q;
  assign bus.digit_idx  = idx_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Drives three scanner configurations in lockstep and compares each against a
// tick-position reference model every cycle.
module tb_display_scan_ctrl;

  localparam int NCFG = 3;

  logic        clk;
  logic        rst_n;
  logic        tick_r;
  logic        en_r;
  logic [31:0] dig_r;
  logic [7:0]  dp_r;
  logic [7:0]  blank_r;

  int n_checks = 0;
  int n_fail   = 0;

  display_scan_if #(.DIGITS(4)) if0 ();
  display_scan_if #(.DIGITS(4)) if1 ();
  display_scan_if #(.DIGITS(3)) if2 ();

  assign if0.tick = tick_r;  assign if0.enable = en_r;
  assign if1.tick = tick_r;  assign if1.enable = en_r;
  assign if2.tick = tick_r;  assign if2.enable = en_r;
  assign if0.digits = dig_r[15:0];  assign if0.dp_in = dp_r[3:0];  assign if0.blank_in = blank_r[3:0];
  assign if1.digits = dig_r[15:0];  assign if1.dp_in = dp_r[3:0];  assign if1.blank_in = blank_r[3:0];
  assign if2.digits = dig_r[11:0];  assign if2.dp_in = dp_r[2:0];  assign if2.blank_in = blank_r[2:0];

  display_scan_ctrl #(.DIGITS(4), .GUARD(1)) dut0 (.fastclock(clk), .reset(rst_n), .bus(if0));
  display_scan_ctrl #(.DIGITS(4), .GUARD(0)) dut1 (.fastclock(clk), .reset(rst_n), .bus(if1));
  display_scan_ctrl #(.DIGITS(3), .GUARD(2)) dut2 (.fastclock(clk), .reset(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nd(input int c);
    return (c == 2) ? 3 : 4;
  endfunction

  function automatic int ng(input int c);
    case (c)
      0:       return 1;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  // Model: position in ticks within a frame; each slot is 1 show tick + ng guard ticks.
  bit         m_active [NCFG];
  int         m_pos    [NCFG];
  logic [3:0] m_hex    [NCFG];
  bit         m_dp     [NCFG];
  bit         m_blank  [NCFG];
  bit         m_fd     [NCFG];

  task automatic model_reset(input int c);
    m_active[c] = 0;
    m_pos[c]    = 0;
    m_hex[c]    = 4'h0;
    m_dp[c]     = 0;
    m_blank[c]  = 0;
    m_fd[c]     = 0;
  endtask

  task automatic latch_slot(input int c, input int s);
    m_hex[c]   = 4'((dig_r >> (4 * s)) & 32'hF);
    m_dp[c]    = dp_r[s];
    m_blank[c] = blank_r[s];
  endtask

  task automatic model_step();
    for (int c = 0; c < NCFG; c++) begin
      int len;
      int total;
      len   = ng(c) + 1;
      total = nd(c) * len;
      if (!rst_n) model_reset(c);
      else if (!en_r) begin
        m_active[c] = 0;
        m_pos[c]    = 0;
        m_fd[c]     = 0;
      end else if (tick_r) begin
        if (!m_active[c]) begin
          m_active[c] = 1;
          m_pos[c]    = 0;
          m_fd[c]     = 0;
          latch_slot(c, 0);
        end else begin
          m_fd[c]  = (m_pos[c] == total - 1);
          m_pos[c] = (m_pos[c] + 1) % total;
          if (m_pos[c] % len == 0) latch_slot(c, m_pos[c] / len);
        end
      end else m_fd[c] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] o_an [NCFG];
    logic [31:0] o_hex[NCFG];
    logic [31:0] o_dp [NCFG];
    logic [31:0] o_idx[NCFG];
    logic [31:0] o_fd [NCFG];
    o_an[0] = 32'(if0.an);  o_hex[0] = 32'(if0.hex);  o_dp[0] = 32'(if0.dp);
    o_idx[0] = 32'(if0.digit_idx);  o_fd[0] = 32'(if0.frame_done);
    o_an[1] = 32'(if1.an);  o_hex[1] = 32'(if1.hex);  o_dp[1] = 32'(if1.dp);
    o_idx[1] = 32'(if1.digit_idx);  o_fd[1] = 32'(if1.frame_done);
    o_an[2] = 32'(if2.an);  o_hex[2] = 32'(if2.hex);  o_dp[2] = 32'(if2.dp);
    o_idx[2] = 32'(if2.digit_idx);  o_fd[2] = 32'(if2.frame_done);
    for (int c = 0; c < NCFG; c++) begin
      int          len;
      int          slot;
      bit          showing;
      logic [31:0] mask;
      logic [31:0] e_an;
      len     = ng(c) + 1;
      slot    = m_pos[c] / len;
      showing = m_active[c] && (m_pos[c] % len == 0);
      mask    = (32'd1 << nd(c)) - 32'd1;
      e_an    = (showing && !m_blank[c]) ? (mask & ~(32'd1 << slot)) : mask;
      check($sformatf("c%0d_an", c),  o_an[c],  e_an);
      check($sformatf("c%0d_idx", c), o_idx[c], m_active[c] ? 32'(slot) : 32'd0);
      check($sformatf("c%0d_hex", c), o_hex[c], 32'(m_hex[c]));
      check($sformatf("c%0d_dp", c),  o_dp[c],  32'(m_dp[c]));
      check($sformatf("c%0d_frame_done", c), o_fd[c], 32'(m_fd[c]));
      check($sformatf("c%0d_one_anode", c),
            32'((nd(c) - $countones(o_an[c] & mask)) <= 1), 32'd1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_ticks(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      tick_r = (k % period == period - 1);
      step();
    end
    tick_r = 1'b0;
  endtask

  // Advance with a tick every 10 cycles until config 0 shows slot s (guard=0) or its guard.
  task automatic wait_pos(input string tag, input int s, input bit want_guard);
    bit found;
    found = 0;
    for (int k = 0; k < 400; k++) begin
      if (m_active[0] && ((!want_guard && m_pos[0] == 2 * s) ||
                          (want_guard && m_pos[0] % 2 == 1))) begin
        found = 1;
        break;
      end
      tick_r = (k % 10 == 9);
      step();
    end
    tick_r = 1'b0;
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    tick_r  = 1'b0;
    en_r    = 1'b0;
    dig_r   = '0;
    dp_r    = '0;
    blank_r = '0;
    for (int c = 0; c < NCFG; c++) model_reset(c);

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Enable alone does not start the scan; the first tick does.
    en_r  = 1'b1;
    dig_r = 32'h0000_4321;
    step();
    run_ticks(240, 10);

    blank_r = 8'b0000_0100;
    run_ticks(160, 10);
    blank_r = '0;

    wait_pos("wait_slot1", 1, 1'b0);
    dig_r = 32'h0000_9999;
    run_ticks(40, 10);
    dig_r = 32'h0000_4321;

    // Enable drop coincident with a tick during slot 3, then restart.
    wait_pos("wait_slot3", 3, 1'b0);
    en_r   = 1'b0;
    tick_r = 1'b1;
    step();
    tick_r = 1'b0;
    en_r   = 1'b1;
    step();
    run_ticks(40, 10);

    dp_r = 8'b1010_0101;
    tick_r = 1'b1;
    repeat (6) step();
    tick_r = 1'b0;
    step();

    // Asynchronous reset pulse between clock edges during a guard slot.
    wait_pos("wait_guard", 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++) model_reset(c);
    check_all();
    #1 rst_n = 1'b1;
    step();
    run_ticks(60, 10);

    for (int k = 0; k < 2000; k++) begin
      tick_r = ($urandom_range(0, 2) == 0);
      en_r   = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 19) == 0) dig_r   = $urandom;
      if ($urandom_range(0, 29) == 0) dp_r    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 29) == 0)
        blank_r = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter GUARD, default 1, ticks of all-anodes-off between digits (legal 0..3).
REQ-003 SHALL have port fastclock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 SHALL have port tick  input  1  scan-rate enable from the slow clock divider; each fastclock cycle with tick=1 counts as one tick.
REQ-006 SHALL have port enable  input  1  scan enable; 0 forces idle.
REQ-007 SHALL have port digits  input  4*DIGITS  hex value per digit; digit i at bits [4i+3:4i].
REQ-008 SHALL have port dp_in  input  DIGITS  decimal point per digit, active-high.
REQ-009 SHALL have port blank_in  input  DIGITS  per-digit suppress, 1 = anode stays off during that digit's slot.
REQ-010 SHALL have port an  output  DIGITS  anode drives, active-low, registered.
REQ-011 SHALL have port hex  output  4  value of the currently shown digit, registered.
REQ-012 SHALL have port dp  output  1  decimal point of the currently shown digit, registered.
REQ-013 SHALL have port digit_idx  output  3  index of the current digit slot, registered.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse on completion of the last digit slot.

Function
REQ-015 SHALL implement FSM states IDLE, SHOW, GUARD; all outputs are registered and change one cycle after the sampled condition.
REQ-016 IDLE: an = all ones, digit_idx = 0; on enable=1 and tick=1 -> SHOW with digit_idx = 0.
REQ-017 On entry to SHOW, hex, dp and the blank decision SHALL be latched from digits/dp_in/blank_in at digit_idx and held for the whole slot; input changes mid-slot have no effect until the next slot.
REQ-018 SHOW: an = all ones except bit digit_idx = 0, unless the latched blank bit is 1, in which case an = all ones.
REQ-019 SHOW with tick=1: if GUARD = 0 -> SHOW at the next index directly; else -> GUARD with the guard counter loaded to GUARD.
REQ-020 GUARD: an = all ones, hex/dp hold; each tick decrements the guard counter; on the tick that reaches 0 -> SHOW at the next index.
REQ-021 Next index SHALL be digit_idx+1, wrapping from DIGITS-1 to 0; the wrap advance (leaving the last slot, including its guard) SHALL pulse frame_done for exactly one cycle.
REQ-022 enable=0 in any state SHALL force IDLE on the next edge (an all ones, digit_idx 0, guard counter cleared) and suppresses frame_done; enable beats a simultaneous tick.
REQ-023 tick held high for N consecutive cycles SHALL count as N ticks.
REQ-024 At most one anode SHALL be low in any cycle; no cycle SHALL have two different digits' anodes low across a state change.

Reset
REQ-025 While reset=0: state IDLE, an all ones, hex 0, dp 0, digit_idx 0, frame_done 0, guard counter 0; effective immediately, independent of fastclock.
REQ-026 After reset deasserts, the block SHALL wait in IDLE for enable=1 and a tick; a reset mid-slot abandons the frame without a frame_done pulse.

Verification (DIGITS=4, GUARD=1 unless stated)
REQ-027 digits=0x4321, dp_in=0, blank_in=0, enable=1, tick every 10 cycles -> an sequence 1110, 1111, 1101, 1111, 1011, 1111, 0111, 1111, repeating; hex 1,2,3,4; frame_done one pulse per 8 ticks.
REQ-028 GUARD=0, same stimulus -> an 1110, 1101, 1011, 0111 with no all-ones gap; frame_done one pulse per 4 ticks.
REQ-029 blank_in=0100 -> slot 2 an stays 1111 for its whole dwell, digit_idx still reaches 2, frame timing unchanged.
REQ-030 Change digits from 0x4321 to 0x9999 mid-slot 1 -> hex stays 2 until slot end; slot 2 shows 9.
REQ-031 enable dropped together with a tick during slot 3 -> next cycle an 1111, digit_idx 0, no frame_done; re-enable restarts at slot 0.
REQ-032 reset pulsed low during GUARD -> an 1111, hex 0, digit_idx 0 immediately with no clock edge; scanning resumes from slot 0 on the next tick after release.
